// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm clock sequencer and its time-field editor.
package alarm_pkg;

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArmed    = 2'd1,
    StRinging  = 2'd2,
    StSnoozing = 2'd3
  } alarm_state_e;

  typedef enum logic [1:0] {
    FldNone    = 2'd0,
    FldHours   = 2'd1,
    FldMinutes = 2'd2,
    FldSeconds = 2'd3
  } set_field_e;

  localparam int unsigned DefHw = 2;
  localparam int unsigned DefMw = 2;
  localparam int unsigned DefSw = 4;

  function automatic set_field_e next_field(input set_field_e fld);
    unique case (fld)
      FldNone:    return FldHours;
      FldHours:   return FldMinutes;
      FldMinutes: return FldSeconds;
      default:    return FldNone;
    endcase
  endfunction

endpackage

// File: rtl/alarm_time_editor.sv
// Programmed alarm time: edit-field selection plus three wrapping field registers.
module alarm_time_editor
  import alarm_pkg::*;
#(
  parameter int unsigned HW = DefHw,
  parameter int unsigned MW = DefMw,
  parameter int unsigned SW = DefSw
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          mode_i,
  input  logic          inc_i,
  output logic [1:0]    set_field_o,
  output logic [HW-1:0] hours_o,
  output logic [MW-1:0] minutes_o,
  output logic [SW-1:0] seconds_o
);

  set_field_e    field_q, field_d;
  logic [HW-1:0] hours_q, hours_d;
  logic [MW-1:0] minutes_q, minutes_d;
  logic [SW-1:0] seconds_q, seconds_d;

  // Increment targets the field selected before any same-cycle mode press.
  always_comb begin
    field_d   = field_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (mode_i) field_d = next_field(field_q);
    if (inc_i) begin
      unique case (field_q)
        FldHours:   hours_d   = hours_q + 1'b1;
        FldMinutes: minutes_d = minutes_q + 1'b1;
        FldSeconds: seconds_d = seconds_q + 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      field_q   <= FldNone;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
    end else begin
      field_q   <= field_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign set_field_o = field_q;
  assign hours_o     = hours_q;
  assign minutes_o   = minutes_q;
  assign seconds_o   = seconds_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm control FSM: arms/disarms, rings on a rising match, handles snooze and ring timeout,
// and drives the buzzer. Alarm time editing is delegated to alarm_time_editor.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned HW           = DefHw,
  parameter int unsigned MW           = DefMw,
  parameter int unsigned SW           = DefSw,
  parameter int unsigned RING_TICKS   = 8,
  parameter int unsigned SNOOZE_TICKS = 5,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          tick_i,
  input  logic          match_i,
  input  logic          btn_mode_i,
  input  logic          btn_inc_i,
  input  logic          btn_arm_i,
  input  logic          btn_stop_i,
  input  logic          btn_snooze_i,
  output logic [HW-1:0] alarm_hours_o,
  output logic [MW-1:0] alarm_minutes_o,
  output logic [SW-1:0] alarm_seconds_o,
  output logic [1:0]    set_field_o,
  output logic          armed_o,
  output logic          ringing_o,
  output logic          buzzer_o
);

  localparam int unsigned RcW = $clog2(RING_TICKS + 1);
  localparam int unsigned ScW = $clog2(SNOOZE_TICKS + 1);
  localparam int unsigned NsW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RcW-1:0] RingLoad   = RcW'(RING_TICKS);
  localparam logic [ScW-1:0] SnoozeLoad = ScW'(SNOOZE_TICKS);
  localparam logic [NsW-1:0] SnoozeMax  = NsW'(MAX_SNOOZE);

  alarm_state_e   state_q, state_d;
  logic [RcW-1:0] ring_cnt_q, ring_cnt_d;
  logic [ScW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [NsW-1:0] snooze_num_q, snooze_num_d;
  logic           match_q;
  logic           armed_q, armed_d;
  logic           ringing_q, ringing_d;
  logic           buzzer_q, buzzer_d;
  logic           trigger;
  logic           mode_en;

  assign trigger = match_i & ~match_q & (set_field_o == FldNone);
  assign mode_en = btn_mode_i & ((state_q == StDisarmed) | (state_q == StArmed));

  alarm_time_editor #(
    .HW (HW),
    .MW (MW),
    .SW (SW)
  ) u_editor (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .mode_i      (mode_en),
    .inc_i       (btn_inc_i),
    .set_field_o (set_field_o),
    .hours_o     (alarm_hours_o),
    .minutes_o   (alarm_minutes_o),
    .seconds_o   (alarm_seconds_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StDisarmed;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      snooze_num_q <= '0;
      match_q      <= 1'b0;
      armed_q      <= 1'b0;
      ringing_q    <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      snooze_num_q <= snooze_num_d;
      match_q      <= match_i;
      armed_q      <= armed_d;
      ringing_q    <= ringing_d;
      buzzer_q     <= buzzer_d;
    end
  end

  // Priority: arm > stop > snooze > timer expiry > trigger.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    snooze_num_d = snooze_num_q;
    unique case (state_q)
      StDisarmed: begin
        if (btn_arm_i) state_d = StArmed;
      end
      StArmed: begin
        if (btn_arm_i) begin
          state_d = StDisarmed;
        end else if (trigger) begin
          state_d      = StRinging;
          ring_cnt_d   = RingLoad;
          snooze_num_d = '0;
        end
      end
      StRinging: begin
        if (btn_arm_i) begin
          state_d = StDisarmed;
        end else if (btn_stop_i) begin
          state_d = StArmed;
        end else if (btn_snooze_i) begin
          if (snooze_num_q < SnoozeMax) begin
            state_d      = StSnoozing;
            snooze_cnt_d = SnoozeLoad;
            snooze_num_d = snooze_num_q + 1'b1;
          end else begin
            state_d = StArmed;
          end
        end else if (tick_i) begin
          if (ring_cnt_q == RcW'(1)) state_d = StArmed;
          else ring_cnt_d = ring_cnt_q - 1'b1;
        end
      end
      StSnoozing: begin
        if (btn_arm_i) begin
          state_d = StDisarmed;
        end else if (btn_stop_i) begin
          state_d = StArmed;
        end else if (tick_i) begin
          if (snooze_cnt_q == ScW'(1)) begin
            state_d    = StRinging;
            ring_cnt_d = RingLoad;
          end else begin
            snooze_cnt_d = snooze_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = StDisarmed;
    endcase
  end

  // Buzzer starts high on ring entry and toggles per tick while the ring continues.
  always_comb begin
    armed_d   = (state_d != StDisarmed);
    ringing_d = (state_d == StRinging);
    buzzer_d  = 1'b0;
    if (state_d == StRinging) begin
      if (state_q != StRinging) buzzer_d = 1'b1;
      else buzzer_d = tick_i ? ~buzzer_q : buzzer_q;
    end
  end

  assign armed_o   = armed_q;
  assign ringing_o = ringing_q;
  assign buzzer_o  = buzzer_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios then random stimulus, every
// cycle compared against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

  localparam int RingT = 8;
  localparam int SnzT  = 5;
  localparam int MaxS  = 3;
  localparam int Dis = 0, Arm = 1, Ring = 2, Snz = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, tick = 1'b0, match = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_arm = 1'b0, btn_stop = 1'b0, btn_snooze = 1'b0;
  logic [1:0] hours, minutes, set_field;
  logic [3:0] seconds;
  logic       armed, ringing, buzzer;

  alarm_sequencer #(
    .HW           (2),
    .MW           (2),
    .SW           (4),
    .RING_TICKS   (RingT),
    .SNOOZE_TICKS (SnzT),
    .MAX_SNOOZE   (MaxS)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .tick_i          (tick),
    .match_i         (match),
    .btn_mode_i      (btn_mode),
    .btn_inc_i       (btn_inc),
    .btn_arm_i       (btn_arm),
    .btn_stop_i      (btn_stop),
    .btn_snooze_i    (btn_snooze),
    .alarm_hours_o   (hours),
    .alarm_minutes_o (minutes),
    .alarm_seconds_o (seconds),
    .set_field_o     (set_field),
    .armed_o         (armed),
    .ringing_o       (ringing),
    .buzzer_o        (buzzer)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model state.
  int m_st, m_fld, m_h, m_m, m_s, m_ring, m_snz, m_nsnz, m_buzz, m_prev;

  function automatic void model_step();
    int  old;
    bit  trig;
    if (reset) begin
      m_st = Dis; m_fld = 0; m_h = 0; m_m = 0; m_s = 0;
      m_ring = 0; m_snz = 0; m_nsnz = 0; m_buzz = 0; m_prev = 0;
      return;
    end
    old    = m_st;
    trig   = match && (m_prev == 0) && (m_fld == 0);
    m_prev = int'(match);
    if (btn_inc) begin
      case (m_fld)
        1: m_h = (m_h + 1) % 4;
        2: m_m = (m_m + 1) % 4;
        3: m_s = (m_s + 1) % 16;
        default: ;
      endcase
    end
    if (btn_mode && (old == Dis || old == Arm)) m_fld = (m_fld + 1) % 4;
    if (old == Dis) begin
      if (btn_arm) m_st = Arm;
    end else if (btn_arm) begin
      m_st = Dis;
    end else if (old == Arm) begin
      if (trig) begin m_st = Ring; m_ring = RingT; m_nsnz = 0; end
    end else if (btn_stop) begin
      m_st = Arm;
    end else if (old == Ring) begin
      if (btn_snooze) begin
        if (m_nsnz < MaxS) begin m_st = Snz; m_snz = SnzT; m_nsnz++; end
        else m_st = Arm;
      end else if (tick) begin
        m_ring--;
        if (m_ring == 0) m_st = Arm;
      end
    end else if (tick) begin
      m_snz--;
      if (m_snz == 0) begin m_st = Ring; m_ring = RingT; end
    end
    if (m_st != Ring) m_buzz = 0;
    else if (old != Ring) m_buzz = 1;
    else if (tick) m_buzz = 1 - m_buzz;
  endfunction

  // One clock: model follows the edge, outputs sampled 1 time unit later, pulses cleared.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("hours", hours, m_h);
    check_val("minutes", minutes, m_m);
    check_val("seconds", seconds, m_s);
    check_val("set_field", set_field, m_fld);
    check_val("armed", armed, (m_st != Dis));
    check_val("ringing", ringing, (m_st == Ring));
    check_val("buzzer", buzzer, m_buzz);
    reset = 0; tick = 0; btn_mode = 0; btn_inc = 0;
    btn_arm = 0; btn_stop = 0; btn_snooze = 0;
  endtask

  initial begin
    reset = 1; cycle();
    check_val("rst_armed", armed, 0);
    check_val("rst_field", set_field, 0);

    // Editing: hours wraps at 4, seconds at 16.
    btn_mode = 1; cycle();
    check_val("edit_sel_hours", set_field, 1);
    repeat (5) begin btn_inc = 1; cycle(); end
    check_val("edit_hours_wrap", hours, 1);
    btn_mode = 1; cycle(); btn_mode = 1; cycle();
    repeat (17) begin btn_inc = 1; cycle(); end
    check_val("edit_seconds_wrap", seconds, 1);
    btn_mode = 1; cycle();
    check_val("edit_back_none", set_field, 0);

    // Match while disarmed is ignored.
    match = 1; cycle();
    check_val("disarmed_no_ring", ringing, 0);
    match = 0; cycle();
    btn_arm = 1; cycle();
    check_val("arm", armed, 1);

    // Match while editing minutes is ignored.
    btn_mode = 1; cycle(); btn_mode = 1; cycle();
    check_val("sel_minutes", set_field, 2);
    match = 1; cycle();
    check_val("editing_no_ring", ringing, 0);
    match = 0; cycle();
    btn_mode = 1; cycle(); btn_mode = 1; cycle();

    // Ring, auto-timeout after RingT ticks, held match does not re-ring.
    match = 1; cycle();
    check_val("ring_start", ringing, 1);
    check_val("buzz_start", buzzer, 1);
    repeat (RingT - 1) begin tick = 1; cycle(); cycle(); end
    check_val("ring_before_timeout", ringing, 1);
    tick = 1; cycle();
    check_val("ring_timeout", ringing, 0);
    check_val("timeout_armed", armed, 1);
    repeat (10) begin tick = 1; cycle(); end
    check_val("held_match_no_rering", ringing, 0);
    match = 0; cycle();

    // Mode button while ringing leaves set_field alone.
    match = 1; cycle(); match = 0;
    btn_mode = 1; cycle();
    check_val("mode_in_ring", set_field, 0);

    // Three snoozes re-ring; the fourth acts as stop.
    for (int k = 0; k < MaxS; k++) begin
      btn_snooze = 1; cycle();
      check_val("snooze_quiet", ringing, 0);
      repeat (SnzT - 1) begin tick = 1; cycle(); end
      check_val("snooze_hold", ringing, 0);
      tick = 1; cycle();
      check_val("snooze_rering", ringing, 1);
      check_val("snooze_rebuzz", buzzer, 1);
    end
    btn_snooze = 1; cycle();
    check_val("snooze4_stop", ringing, 0);
    repeat (SnzT + 1) begin tick = 1; cycle(); end
    check_val("snooze4_no_rering", ringing, 0);

    // arm beats stop in the same cycle.
    match = 1; cycle(); match = 0;
    check_val("ring_again", ringing, 1);
    btn_arm = 1; btn_stop = 1; cycle();
    check_val("arm_over_stop", armed, 0);

    // stop coinciding with the timeout tick ends in ARMED.
    btn_arm = 1; cycle();
    match = 1; cycle(); match = 0;
    repeat (RingT - 1) begin tick = 1; cycle(); end
    check_val("pre_timeout_ring", ringing, 1);
    btn_stop = 1; tick = 1; cycle();
    check_val("stop_tick_armed", armed, 1);
    check_val("stop_tick_quiet", ringing, 0);

    // Reset mid-ring.
    match = 1; cycle(); match = 0;
    check_val("ring_pre_reset", ringing, 1);
    reset = 1; cycle();
    check_val("reset_ring", ringing, 0);
    check_val("reset_buzz", buzzer, 0);
    check_val("reset_armed", armed, 0);
    check_val("reset_hours", hours, 0);
    check_val("reset_seconds", seconds, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick       = ($urandom_range(3) == 0);
      if ($urandom_range(5) == 0) match = ~match;
      btn_mode   = ($urandom_range(19) == 0);
      btn_inc    = ($urandom_range(7) == 0);
      btn_arm    = ($urandom_range(29) == 0);
      btn_stop   = ($urandom_range(39) == 0);
      btn_snooze = ($urandom_range(14) == 0);
      reset      = ($urandom_range(499) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
